rotate_scatter_writer: RTL and testbench
========================================

# rotate_scatter_writer

Downstream stage of the pixel rotation block: accepts rotated `(x, y, pixel)` samples, discards samples whose coordinates land outside the frame, and converts the rest into linear frame-buffer write transactions. A small FIFO absorbs memory back-pressure, and an optional clear pass fills the frame with a background value. The block sits between the rotation stage and the frame-memory write port.

## Interface
- `DATA_WIDTH`, 8: pixel width.
- `IMG_WIDTH`, 640: frame width in pixels.
- `IMG_HEIGHT`, 480: frame height in pixels.
- `ADDR_WIDTH`, 19: memory address width; must satisfy ≥ clog2(IMG_WIDTH*IMG_HEIGHT).
- `FIFO_DEPTH`, 16: write FIFO entries; power of two, ≥ 4.
- `BG_VALUE`, 0: pixel value written during the clear pass.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  block accepts a sample this cycle.
- `in_last`  in  1  marks the final sample of the frame; qualified by the handshake.
- `pixel_in`  in  DATA_WIDTH  pixel value.
- `x_in`  in  16  rotated x, two's-complement signed.
- `y_in`  in  16  rotated y, two's-complement signed.
- `mem_valid`  out  1  write request valid.
- `mem_ready`  in  1  memory accepts the write.
- `mem_addr`  out  ADDR_WIDTH  linear address, computed as y*IMG_WIDTH + x.
- `mem_data`  out  DATA_WIDTH  write data.
- `frame_done`  out  1  one-cycle pulse when every write of the frame has been accepted.
- `drop_count`  out  16  out-of-bounds samples dropped in the current frame; saturates at 16'hFFFF.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, CLEAR, RUN, FLUSH.
- **IDLE**
  - On `frame_start`: clear `drop_count`.
  - Go to CLEAR when the clear feature is compiled in, otherwise go to RUN.
- **CLEAR**
  - `in_ready` = 0.
  - An address counter drives `mem_valid` = 1, `mem_data` = BG_VALUE, and `mem_addr` = counter.
  - The counter advances on each accepted write (`mem_valid && mem_ready`).
  - After address IMG_WIDTH*IMG_HEIGHT-1 is accepted, go to RUN. The FIFO is bypassed in this state and is guaranteed empty on entry.
- **RUN**
  - `in_ready` = (fifo_count ≤ FIFO_DEPTH-3). This reserves space for the 2 in-flight pipeline stages, so the FIFO never overflows.
  - An accepted sample is in-bounds iff 0 ≤ x < IMG_WIDTH and 0 ≤ y < IMG_HEIGHT, with both coordinates compared as signed values.
  - An out-of-bounds sample is dropped and increments `drop_count`.
  - An in-bounds sample travels through a 2-stage pipeline (S1: clip and register; S2: address multiply-add and register) and is then written into the FIFO.
  - Accepting a sample with `in_last` = 1 moves the block to FLUSH, whether that sample is in or out of bounds.
- **FLUSH**
  - `in_ready` = 0.
  - Wait until S1, S2 and the FIFO are all empty and no write is pending.
  - Then pulse `frame_done` for one cycle and return to IDLE.
- **FIFO and write port**
  - The FIFO is show-ahead: its head drives `mem_addr` and `mem_data`, and `mem_valid` = !empty.
  - Once `mem_valid` is asserted, `mem_addr` and `mem_data` stay stable until `mem_ready` is seen.
- **Address arithmetic**
  - Address = y[ADDR_WIDTH-1:0]*IMG_WIDTH + x, computed unsigned after the bounds check and truncated to ADDR_WIDTH.
  - Duplicate addresses within a frame are written in arrival order; the last write wins.
- **Boundary conditions**
  - `frame_start` outside IDLE is ignored.
  - Inputs are ignored while `in_ready` = 0.
  - If a FIFO write and FIFO read occur in the same cycle, the count is unchanged.
  - Reset mid-operation: state returns to IDLE, the FIFO and pipeline are flushed, and the outstanding write is abandoned.

## Timing
- Reset values: `in_ready` 0, `mem_valid` 0, `mem_addr` 0, `mem_data` 0, `frame_done` 0, `drop_count` 0, `busy` 0.
- `frame_start` in cycle N → `busy` = 1 in cycle N+1. In N+1 the block is either in CLEAR with `mem_valid` = 1, or in RUN with `in_ready` = 1.
- Sample accepted in cycle N with the FIFO empty → `mem_valid` = 1 with its address in N+3.
- With `mem_ready` held high, throughput is one write per cycle.
- `frame_done` follows the acceptance of the final write by exactly 1 cycle.
- The CLEAR pass takes IMG_WIDTH*IMG_HEIGHT cycles when `mem_ready` = 1 throughout.

## Configuration
- `ROT_WR_CLEAR_EN` defined:
  - The CLEAR state and address counter are present.
  - Every frame starts with a full background fill, so holes left by forward mapping read as BG_VALUE.
- `ROT_WR_CLEAR_EN` undefined:
  - The CLEAR logic is removed and IDLE goes directly to RUN.
  - Unwritten locations keep the previous frame's content.

## Structure
- Package `rotate_pkg` holds:
  - the state enum (IDLE, CLEAR, RUN, FLUSH);
  - the frame-size constants and the derived `FRAME_PIXELS` = IMG_WIDTH*IMG_HEIGHT;
  - a bounds-check function on signed 16-bit coordinates.
- Sub-module `rotate_wr_fifo` is a parameterised synchronous show-ahead FIFO with a count output, instantiated once.

## Test plan
- 4×4 frame, clear enabled, `mem_ready` = 1 → 16 writes of BG_VALUE to addresses 0..15, then `in_ready` = 1.
- Samples (0,0,8'hA1), (3,3,8'hB2), (2,1,8'hC3) with `in_last` on the third → writes addr 0/A1, 15/B2, 6/C3; `frame_done` 1 cycle after the last write is accepted; `drop_count` = 0.
- Samples at x = -1 (16'hFFFF), x = 4, y = 4 and (1,1) → only addr 5 is written; `drop_count` = 3.
- `mem_ready` = 0 for 20 cycles while streaming in-bounds samples → `in_ready` drops when fifo_count reaches FIFO_DEPTH-2; no sample is lost or duplicated; `mem_addr` stays stable while stalled.
- `rst` asserted mid-RUN with 5 entries queued → next cycle `mem_valid` = 0, `busy` = 0, `drop_count` = 0; a new `frame_start` operates normally.
- `frame_start` pulsed during RUN → ignored; state and counters unchanged.

Source files
------------

// File: rtl/rotate_pkg.sv
// Shared definitions for the rotate scatter writer: FSM state encoding,
// default frame geometry, pipeline depth and the signed bounds check.
package rotate_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2,
      ST_FLUSH = 2'd3
   } wr_state_t;

   localparam int DEF_IMG_WIDTH  = 640;
   localparam int DEF_IMG_HEIGHT = 480;
   localparam int FRAME_PIXELS   = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;

   // Number of registered stages between the input handshake and the FIFO;
   // the FIFO keeps this many slots in reserve for samples still in flight.
   localparam int PIPE_STAGES = 2;

   // True when (x, y) lands inside a width x height frame. Both coordinates
   // are two's-complement, so negative values are rejected before any
   // unsigned address arithmetic happens.
   function automatic logic in_frame(input logic signed [15:0] x,
                                     input logic signed [15:0] y,
                                     input int                 width,
                                     input int                 height);
      int xs;
      int ys;
      xs = int'(x);
      ys = int'(y);
      return (xs >= 0) && (xs < width) && (ys >= 0) && (ys < height);
   endfunction

endpackage

// File: rtl/rotate_wr_fifo.sv
// Synchronous show-ahead FIFO with occupancy count. The head entry is visible
// on rd_data whenever empty is low; rd_en pops it. Writes when full and reads
// when empty are ignored. Storage is not reset, only pointers and count.
module rotate_wr_fifo
   import rotate_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign do_wr   = wr_en && (count != CNT_W'(DEPTH));
   assign do_rd   = rd_en && (count != '0);
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   // Storage array: written at the tail, no reset needed for data.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leave count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rotate_scatter_writer.sv
// Rotate scatter writer: takes rotated (x, y, pixel) samples, drops the ones
// outside the frame, turns the rest into linear frame-buffer writes through a
// two-stage pipeline and a show-ahead FIFO that absorbs memory back-pressure.
// Optional feature macro ROT_WR_CLEAR_EN: when defined, every frame begins
// with a CLEAR pass that writes BG_VALUE to every pixel address.
module rotate_scatter_writer
   import rotate_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int ADDR_WIDTH = 19,
   parameter int FIFO_DEPTH = 16,
   parameter int BG_VALUE   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_last,
   input  logic [DATA_WIDTH-1:0] pixel_in,
   input  logic [15:0]           x_in,
   input  logic [15:0]           y_in,
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  frame_done,
   output logic [15:0]           drop_count,
   output logic                  busy
);

   localparam int N_PIXELS = IMG_WIDTH * IMG_HEIGHT;
   localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
   localparam int FIFO_W   = ADDR_WIDTH + DATA_WIDTH;

   // Reject parameter sets the datapath cannot represent.
   if (ADDR_WIDTH < $clog2(N_PIXELS) || FIFO_DEPTH < 4 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       BG_VALUE < 0 || BG_VALUE >= (1 << DATA_WIDTH)) begin : g_bad_params
      $error("rotate_scatter_writer: illegal parameter combination");
   end

   wr_state_t state;
   wr_state_t state_n;

   logic                  accept;
   logic                  in_bnd;
   logic                  flush_idle;

   logic                  vld_p1;
   logic [ADDR_WIDTH-1:0] x_p1;
   logic [ADDR_WIDTH-1:0] y_p1;
   logic [DATA_WIDTH-1:0] pix_p1;

   logic                  vld_p2;
   logic [ADDR_WIDTH-1:0] addr_p2;
   logic [DATA_WIDTH-1:0] pix_p2;

   logic                  fifo_rd;
   logic                  fifo_empty;
   logic [CNT_W-1:0]      fifo_count;
   logic [FIFO_W-1:0]     fifo_head;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_data;

`ifdef ROT_WR_CLEAR_EN
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic                  clr_last;
   assign clr_last = (clr_cnt == ADDR_WIDTH'(N_PIXELS - 1));
`endif

   // Input side: space is reserved for samples already in S1/S2.
   assign in_ready   = (state == ST_RUN) &&
                       (fifo_count <= CNT_W'(FIFO_DEPTH - 1 - PIPE_STAGES));
   assign accept     = in_valid && in_ready;
   assign in_bnd     = in_frame(x_in, y_in, IMG_WIDTH, IMG_HEIGHT);
   assign flush_idle = !vld_p1 && !vld_p2 && fifo_empty;
   assign busy       = (state != ST_IDLE);
   assign {head_addr, head_data} = fifo_head;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic and the frame_done pulse.
   always_comb begin
      state_n    = state;
      frame_done = 1'b0;
      case (state)
         ST_IDLE: begin
            if (frame_start) begin
`ifdef ROT_WR_CLEAR_EN
               state_n = ST_CLEAR;
`else
               state_n = ST_RUN;
`endif
            end
         end
`ifdef ROT_WR_CLEAR_EN
         ST_CLEAR: begin
            if (mem_ready && clr_last) begin
               state_n = ST_RUN;
            end
         end
`endif
         ST_RUN: begin
            if (accept && in_last) begin
               state_n = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (flush_idle) begin
               frame_done = 1'b1;
               state_n    = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Write port mux: clear counter during CLEAR, FIFO head otherwise. Outputs
   // rest at zero when nothing is offered.
   always_comb begin
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_data  = '0;
      fifo_rd   = 1'b0;
`ifdef ROT_WR_CLEAR_EN
      if (state == ST_CLEAR) begin
         mem_valid = 1'b1;
         mem_addr  = clr_cnt;
         mem_data  = DATA_WIDTH'(BG_VALUE);
      end else
`endif
      if (!fifo_empty) begin
         mem_valid = 1'b1;
         mem_addr  = head_addr;
         mem_data  = head_data;
         fifo_rd   = mem_ready;
      end
   end

`ifdef ROT_WR_CLEAR_EN
   // Background fill address counter; rearmed whenever the block is idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         clr_cnt <= '0;
      end else if (state == ST_IDLE) begin
         clr_cnt <= '0;
      end else if (state == ST_CLEAR && mem_ready) begin
         clr_cnt <= clr_cnt + 1'b1;
      end
   end
`endif

   // Per-frame count of out-of-bounds samples, saturating.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_count <= '0;
      end else if (state == ST_IDLE && frame_start) begin
         drop_count <= '0;
      end else if (accept && !in_bnd && drop_count != 16'hFFFF) begin
         drop_count <= drop_count + 16'd1;
      end
   end

   // Pipeline valids: only in-bounds samples enter S1.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p1 <= accept && in_bnd;
         vld_p2 <= vld_p1;
      end
   end

   // S1: capture clipped coordinates and pixel.
   always_ff @(posedge clk) begin
      if (accept && in_bnd) begin
         x_p1   <= ADDR_WIDTH'(x_in);
         y_p1   <= ADDR_WIDTH'(y_in);
         pix_p1 <= pixel_in;
      end
   end

   // S2: linear address y*IMG_WIDTH + x, truncated to ADDR_WIDTH.
   always_ff @(posedge clk) begin
      if (vld_p1) begin
         addr_p2 <= y_p1 * ADDR_WIDTH'(IMG_WIDTH) + x_p1;
         pix_p2  <= pix_p1;
      end
   end

   rotate_wr_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (vld_p2),
      .wr_data ({addr_p2, pix_p2}),
      .rd_en   (fifo_rd),
      .rd_data (fifo_head),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

endmodule

// File: tb/tb_rotate_scatter_writer.sv
// Directed bench for rotate_scatter_writer on a 4x4 frame. Works with or
// without ROT_WR_CLEAR_EN defined.
module tb_rotate_scatter_writer;

   localparam int DW = 8;
   localparam int IW = 4;
   localparam int IH = 4;
   localparam int AW = 8;
   localparam int FD = 16;
   localparam int BG = 8'h5A;

   logic          clk = 1'b0;
   logic          rst;
   logic          frame_start;
   logic          in_valid;
   logic          in_ready;
   logic          in_last;
   logic [DW-1:0] pixel_in;
   logic [15:0]   x_in;
   logic [15:0]   y_in;
   logic          mem_valid;
   logic          mem_ready;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          frame_done;
   logic [15:0]   drop_count;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int fd_cnt = 0;
   int fd_cyc = -1;
   logic [AW-1:0] wa_q[$];
   logic [DW-1:0] wd_q[$];
   int            wc_q[$];

   rotate_scatter_writer #(
      .DATA_WIDTH (DW), .IMG_WIDTH (IW), .IMG_HEIGHT (IH),
      .ADDR_WIDTH (AW), .FIFO_DEPTH (FD), .BG_VALUE (BG)
   ) dut (
      .clk (clk), .rst (rst), .frame_start (frame_start),
      .in_valid (in_valid), .in_ready (in_ready), .in_last (in_last),
      .pixel_in (pixel_in), .x_in (x_in), .y_in (y_in),
      .mem_valid (mem_valid), .mem_ready (mem_ready),
      .mem_addr (mem_addr), .mem_data (mem_data),
      .frame_done (frame_done), .drop_count (drop_count), .busy (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Write and frame_done monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_valid === 1'b1 && mem_ready === 1'b1) begin
         wa_q.push_back(mem_addr);
         wd_q.push_back(mem_data);
         wc_q.push_back(cyc);
      end
      if (frame_done === 1'b1) begin
         fd_cnt <= fd_cnt + 1;
         fd_cyc <= cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wq_clear();
      wa_q.delete();
      wd_q.delete();
      wc_q.delete();
   endtask

   task automatic send(input logic [15:0] x, input logic [15:0] y,
                       input logic [7:0] p, input logic last,
                       output int acc_cyc);
      x_in = x; y_in = y; pixel_in = p; in_last = last; in_valid = 1'b1;
      acc_cyc = -1;
      for (int i = 0; i < 300; i++) begin
         if (in_ready === 1'b1) begin
            acc_cyc = cyc;
            break;
         end
         tick();
      end
      if (acc_cyc < 0) begin
         checks++; errors++;
         $display("FAIL send_timeout: in_ready never rose for x=%0h y=%0h", x, y);
      end
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_done(input int base);
      int ok;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         if (fd_cnt > base) begin
            ok = 1;
            break;
         end
         tick();
      end
      checks++;
      if (ok == 0) begin
         errors++;
         $display("FAIL frame_done_timeout: frame_done count %0d, required > %0d", fd_cnt, base);
      end
   endtask

   task automatic begin_frame(output int s, output int r);
      frame_start = 1'b1;
      s = cyc;
      tick();
      frame_start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL start_busy: busy=%b required 1", busy);
      end
`ifdef ROT_WR_CLEAR_EN
      checks++;
      if (mem_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL start_clear: mem_valid=%b in_ready=%b required 1/0", mem_valid, in_ready);
      end
`else
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL start_run: in_ready=%b required 1", in_ready);
      end
`endif
      r = -1;
      for (int i = 0; i < 300; i++) begin
         if (in_ready === 1'b1) begin
            r = cyc;
            break;
         end
         tick();
      end
      checks++;
      if (r < 0) begin
         errors++; $display("FAIL run_timeout: in_ready stayed low after frame_start");
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; frame_start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      pixel_in = '0; x_in = '0; y_in = '0; mem_ready = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (in_ready !== 1'b0 || mem_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: in_ready=%b mem_valid=%b frame_done=%b busy=%b required all 0",
                  in_ready, mem_valid, frame_done, busy);
      end
      checks++;
      if (mem_addr !== 8'h00 || mem_data !== 8'h00 || drop_count !== 16'h0000) begin
         errors++;
         $display("FAIL reset_data: addr=%0h data=%0h drop=%0h required 0", mem_addr, mem_data, drop_count);
      end
      rst = 1'b0;
      mem_ready = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int s, r, a0, a1, a2, base;
      base = fd_cnt;
      wq_clear();
      begin_frame(s, r);
`ifdef ROT_WR_CLEAR_EN
      checks++;
      if (r !== s + 17) begin
         errors++; $display("FAIL clear_len: RUN at cycle %0d required %0d", r, s + 17);
      end
      checks++;
      if (wa_q.size() !== 16) begin
         errors++; $display("FAIL clear_count: %0d writes required 16", wa_q.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (wa_q[i] !== 8'(i) || wd_q[i] !== 8'h5A) begin
               errors++; $display("FAIL clear_write%0d: addr=%0h data=%0h required %0h/5a", i, wa_q[i], wd_q[i], i);
            end
         end
      end
`else
      checks++;
      if (r !== s + 1 || wa_q.size() !== 0) begin
         errors++; $display("FAIL run_entry: RUN at %0d (required %0d), %0d writes (required 0)", r, s + 1, wa_q.size());
      end
`endif
      wq_clear();
      send(16'd0, 16'd0, 8'hA1, 1'b0, a0);
      send(16'd3, 16'd3, 8'hB2, 1'b0, a1);
      send(16'd2, 16'd1, 8'hC3, 1'b1, a2);
      wait_done(base);
      tick();
      checks++;
      if (a1 !== a0 + 1 || a2 !== a0 + 2) begin
         errors++; $display("FAIL basic_accept: cycles %0d %0d %0d required consecutive", a0, a1, a2);
      end
      checks++;
      if (wa_q.size() !== 3) begin
         errors++; $display("FAIL basic_count: %0d writes required 3", wa_q.size());
      end else begin
         checks++;
         if (wa_q[0] !== 8'd0 || wd_q[0] !== 8'hA1 || wa_q[1] !== 8'd15 || wd_q[1] !== 8'hB2 ||
             wa_q[2] !== 8'd6 || wd_q[2] !== 8'hC3) begin
            errors++;
            $display("FAIL basic_writes: %0d/%0h %0d/%0h %0d/%0h required 0/a1 15/b2 6/c3",
                     wa_q[0], wd_q[0], wa_q[1], wd_q[1], wa_q[2], wd_q[2]);
         end
         checks++;
         if (wc_q[0] !== a0 + 3 || wc_q[2] !== a0 + 5) begin
            errors++; $display("FAIL basic_latency: writes at %0d..%0d required %0d..%0d", wc_q[0], wc_q[2], a0 + 3, a0 + 5);
         end
         checks++;
         if (fd_cyc !== wc_q[2] + 1) begin
            errors++; $display("FAIL basic_done_time: frame_done at %0d required %0d", fd_cyc, wc_q[2] + 1);
         end
      end
      checks++;
      if (drop_count !== 16'd0 || busy !== 1'b0 || fd_cnt !== base + 1) begin
         errors++; $display("FAIL basic_end: drop=%0d busy=%b dones=%0d required 0/0/%0d", drop_count, busy, fd_cnt, base + 1);
      end
   endtask

   task automatic test_drop();
      int s, r, a, base;
      base = fd_cnt;
      begin_frame(s, r);
      wq_clear();
      send(16'hFFFF, 16'd0, 8'h01, 1'b0, a);
      send(16'd4,    16'd0, 8'h02, 1'b0, a);
      send(16'd0,    16'd4, 8'h03, 1'b0, a);
      send(16'd1,    16'd1, 8'hD4, 1'b1, a);
      wait_done(base);
      checks++;
      if (wa_q.size() !== 1) begin
         errors++; $display("FAIL drop_count_writes: %0d writes required 1", wa_q.size());
      end else begin
         checks++;
         if (wa_q[0] !== 8'd5 || wd_q[0] !== 8'hD4) begin
            errors++; $display("FAIL drop_write: %0d/%0h required 5/d4", wa_q[0], wd_q[0]);
         end
      end
      checks++;
      if (drop_count !== 16'd3) begin
         errors++; $display("FAIL drop_count: %0d required 3", drop_count);
      end
   endtask

   task automatic test_backpressure();
      int s, r, a, idx, base, stall_bad, stall_seen;
      logic acc;
      base = fd_cnt;
      begin_frame(s, r);
      wq_clear();
      mem_ready = 1'b0;
      idx = 0; stall_bad = 0; stall_seen = 0;
      in_valid = 1'b1; in_last = 1'b0;
      for (int k = 0; k < 20; k++) begin
         x_in = 16'((idx + 1) % 4);
         y_in = 16'(((idx + 1) / 4) % 4);
         pixel_in = 8'h10 + 8'(idx);
         if (mem_valid === 1'b1) begin
            stall_seen++;
            if (mem_addr !== 8'd1 || mem_data !== 8'h10) stall_bad++;
         end
         acc = in_ready;
         tick();
         if (acc === 1'b1) idx++;
      end
      checks++;
      if (idx !== 16) begin
         errors++; $display("FAIL bp_accepted: %0d samples accepted while stalled, required 16", idx);
      end
      checks++;
      if (in_ready !== 1'b0 || mem_valid !== 1'b1 || mem_addr !== 8'd1) begin
         errors++; $display("FAIL bp_stalled: in_ready=%b mem_valid=%b addr=%0d required 0/1/1", in_ready, mem_valid, mem_addr);
      end
      checks++;
      if (stall_bad !== 0 || stall_seen < 15) begin
         errors++; $display("FAIL bp_stable: %0d unstable of %0d stalled cycles, required 0 of >=15", stall_bad, stall_seen);
      end
      mem_ready = 1'b1;
      for (int i = idx; i < 20; i++) begin
         send(16'((i + 1) % 4), 16'(((i + 1) / 4) % 4), 8'h10 + 8'(i), (i == 19), a);
      end
      wait_done(base);
      checks++;
      if (wa_q.size() !== 20) begin
         errors++; $display("FAIL bp_count: %0d writes required 20", wa_q.size());
      end else begin
         for (int i = 0; i < 20; i++) begin
            checks++;
            if (wa_q[i] !== 8'((i + 1) % 16) || wd_q[i] !== 8'h10 + 8'(i)) begin
               errors++; $display("FAIL bp_write%0d: %0d/%0h required %0d/%0h", i, wa_q[i], wd_q[i], (i + 1) % 16, 8'h10 + 8'(i));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int s, r, a, base;
      begin_frame(s, r);
      wq_clear();
      mem_ready = 1'b0;
      send(16'hFFFD, 16'd1, 8'h99, 1'b0, a);
      send(16'd0, 16'd2, 8'h20, 1'b0, a);
      send(16'd1, 16'd2, 8'h21, 1'b0, a);
      send(16'd2, 16'd2, 8'h22, 1'b0, a);
      send(16'd3, 16'd2, 8'h23, 1'b0, a);
      send(16'd0, 16'd3, 8'h24, 1'b0, a);
      tick(); tick(); tick();
      checks++;
      if (drop_count !== 16'd1 || mem_valid !== 1'b1 || mem_addr !== 8'd8) begin
         errors++; $display("FAIL rstmid_pre: drop=%0d mem_valid=%b addr=%0d required 1/1/8", drop_count, mem_valid, mem_addr);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (mem_valid !== 1'b0 || busy !== 1'b0 || drop_count !== 16'd0 || in_ready !== 1'b0) begin
         errors++; $display("FAIL rstmid_post: mem_valid=%b busy=%b drop=%0d in_ready=%b required 0", mem_valid, busy, drop_count, in_ready);
      end
      mem_ready = 1'b1;
      tick();
      base = fd_cnt;
      begin_frame(s, r);
      wq_clear();
      send(16'd2, 16'd2, 8'hEE, 1'b1, a);
      wait_done(base);
      checks++;
      if (wa_q.size() !== 1) begin
         errors++; $display("FAIL rstmid_count: %0d writes required 1", wa_q.size());
      end else begin
         checks++;
         if (wa_q[0] !== 8'd10 || wd_q[0] !== 8'hEE) begin
            errors++; $display("FAIL rstmid_write: %0d/%0h required 10/ee", wa_q[0], wd_q[0]);
         end
      end
   endtask

   task automatic test_ignore_start();
      int s, r, a, base;
      base = fd_cnt;
      begin_frame(s, r);
      wq_clear();
      send(16'hFFFB, 16'hFFFB, 8'h11, 1'b0, a);
      tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b1 || mem_valid !== 1'b0 || drop_count !== 16'd1) begin
         errors++; $display("FAIL ignore_start: busy=%b in_ready=%b mem_valid=%b drop=%0d required 1/1/0/1",
                            busy, in_ready, mem_valid, drop_count);
      end
      tick();
      checks++;
      if (in_ready !== 1'b1 || mem_valid !== 1'b0) begin
         errors++; $display("FAIL ignore_start_hold: in_ready=%b mem_valid=%b required 1/0", in_ready, mem_valid);
      end
      send(16'd3, 16'd0, 8'h77, 1'b1, a);
      wait_done(base);
      checks++;
      if (wa_q.size() !== 1) begin
         errors++; $display("FAIL ignore_count: %0d writes required 1", wa_q.size());
      end else begin
         checks++;
         if (wa_q[0] !== 8'd3 || wd_q[0] !== 8'h77) begin
            errors++; $display("FAIL ignore_write: %0d/%0h required 3/77", wa_q[0], wd_q[0]);
         end
      end
      checks++;
      if (drop_count !== 16'd1) begin
         errors++; $display("FAIL ignore_drop: %0d required 1", drop_count);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_drop();
      test_backpressure();
      test_reset_mid();
      test_ignore_start();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
